// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS IF-stage program-counter unit: control FSM
// encoding, default vectors and the instruction-alignment helper.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } pc_state_e;

  localparam logic [31:0] DEF_RST_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VEC = 32'h0000_0080;
  localparam int unsigned DEF_INC     = 4;

  // Instructions are word aligned, so any set low bit makes a target illegal.
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return (lsb != 2'b00);
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC priority selector: exception, branch, stall, jump, sequential.
// Misaligned branch/jump targets are replaced by the exception vector.
module pc_next_mux
  import mips_pkg::*;
#(
  parameter int              LEN     = 32,
  parameter int unsigned     INC     = DEF_INC,
  parameter logic [LEN-1:0]  EXC_VEC = LEN'(DEF_EXC_VEC)
) (
  input  logic [LEN-1:0] pc,
  input  logic           exc,
  input  logic           branch,
  input  logic [LEN-1:0] branch_tgt,
  input  logic           jump,
  input  logic [LEN-1:0] jump_tgt,
  input  logic           stall,
  output logic [LEN-1:0] next_pc,
  output logic           addr_err
);

  // Priority select; a stalled ID stage blocks its own jump but not a flush.
  always_comb begin
    next_pc  = pc + LEN'(INC);
    addr_err = 1'b0;
    if (exc) begin
      next_pc = EXC_VEC;
    end else if (branch) begin
      if (is_misaligned(branch_tgt[1:0])) begin
        next_pc  = EXC_VEC;
        addr_err = 1'b1;
      end else begin
        next_pc = branch_tgt;
      end
    end else if (stall) begin
      next_pc = pc;
    end else if (jump) begin
      if (is_misaligned(jump_tgt[1:0])) begin
        next_pc  = EXC_VEC;
        addr_err = 1'b1;
      end else begin
        next_pc = jump_tgt;
      end
    end else begin
      next_pc = pc + LEN'(INC);
    end
  end

endmodule

// File: rtl/pc_unit.sv
// IF-stage program counter with run/step/halt debug control and a saturating
// count of enabled cycles. All state updates on the falling clock edge.
module pc_unit
  import mips_pkg::*;
#(
  parameter int             LEN     = 32,
  parameter int unsigned    INC     = DEF_INC,
  parameter logic [LEN-1:0] RST_VEC = LEN'(DEF_RST_VEC),
  parameter logic [LEN-1:0] EXC_VEC = LEN'(DEF_EXC_VEC),
  parameter int             CNT_W   = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_step_mode,
  input  logic             i_step,
  input  logic             i_stall,
  input  logic             i_exc,
  input  logic             i_branch,
  input  logic [LEN-1:0]   i_branch_tgt,
  input  logic             i_jump,
  input  logic [LEN-1:0]   i_jump_tgt,
  input  logic             i_halt,
  output logic [LEN-1:0]   o_pc,
  output logic [LEN-1:0]   o_pc_plus,
  output logic             o_enable,
  output logic             o_halted,
  output logic             o_addr_err,
  output logic [CNT_W-1:0] o_cycle_count
);

  pc_state_e      state_r, state_nxt_s;
  logic [LEN-1:0] pc_r, next_pc_s;
  logic           addr_err_r, mux_err_s, enable_s, halt_ok_s;
  logic [CNT_W-1:0] count_r;

  pc_next_mux #(
    .LEN     (LEN),
    .INC     (INC),
    .EXC_VEC (EXC_VEC)
  ) u_next (
    .pc         (pc_r),
    .exc        (i_exc),
    .branch     (i_branch),
    .branch_tgt (i_branch_tgt),
    .jump       (i_jump),
    .jump_tgt   (i_jump_tgt),
    .stall      (i_stall),
    .next_pc    (next_pc_s),
    .addr_err   (mux_err_s)
  );

  // A halting instruction flushed by an exception or taken branch never retires.
  assign halt_ok_s = i_halt & ~i_exc & ~i_branch;

  // Control FSM next state and pipeline enable.
  always_comb begin
    state_nxt_s = state_r;
    enable_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_start) begin
          state_nxt_s = i_step_mode ? ST_STEP : ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        enable_s = 1'b1;
        if (halt_ok_s) begin
          state_nxt_s = ST_HALTED;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_STEP: begin
        enable_s = i_step;
        if (i_step && halt_ok_s) begin
          state_nxt_s = ST_HALTED;
        end else begin
          state_nxt_s = ST_STEP;
        end
      end
      ST_HALTED: begin
        state_nxt_s = ST_HALTED;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, PC, error pulse and cycle counter; the halting edge still updates PC.
  always_ff @(negedge i_clk) begin
    if (!i_rst) begin
      state_r    <= ST_IDLE;
      pc_r       <= RST_VEC;
      addr_err_r <= 1'b0;
      count_r    <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (enable_s) begin
        pc_r       <= next_pc_s;
        addr_err_r <= mux_err_s;
        if (count_r != {CNT_W{1'b1}}) begin
          count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          count_r <= count_r;
        end
      end else begin
        addr_err_r <= 1'b0;
      end
    end
  end

  assign o_pc          = pc_r;
  assign o_pc_plus     = pc_r + LEN'(INC);
  assign o_enable      = enable_s;
  assign o_halted      = (state_r == ST_HALTED);
  assign o_addr_err    = addr_err_r;
  assign o_cycle_count = count_r;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, step_mode = 1'b0, step = 1'b0, stall = 1'b0;
  logic        exc = 1'b0, branch = 1'b0, jump = 1'b0, halt = 1'b0;
  logic [31:0] bt = 32'h0, jt = 32'h0;

  logic [31:0] pc, pc_plus, cnt;
  logic        en, halted, aerr;
  logic [31:0] pc4, pc_plus4;
  logic        en4, halted4, aerr4;
  logic [3:0]  cnt4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_unit dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_step_mode(step_mode),
    .i_step(step), .i_stall(stall), .i_exc(exc), .i_branch(branch),
    .i_branch_tgt(bt), .i_jump(jump), .i_jump_tgt(jt), .i_halt(halt),
    .o_pc(pc), .o_pc_plus(pc_plus), .o_enable(en), .o_halted(halted),
    .o_addr_err(aerr), .o_cycle_count(cnt)
  );

  pc_unit #(.CNT_W(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_step_mode(step_mode),
    .i_step(step), .i_stall(stall), .i_exc(exc), .i_branch(branch),
    .i_branch_tgt(bt), .i_jump(jump), .i_jump_tgt(jt), .i_halt(halt),
    .o_pc(pc4), .o_pc_plus(pc_plus4), .o_enable(en4), .o_halted(halted4),
    .o_addr_err(aerr4), .o_cycle_count(cnt4)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 run, 2 single-step, 3 halted.
  localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_HALT = 3;
  int          m_mode  = M_IDLE;
  bit          m_valid = 1'b0;
  logic [31:0] m_pc    = 32'h0;
  logic [31:0] m_cnt   = 32'h0;
  int          m_cnt4  = 0;
  logic        m_err   = 1'b0;

  function automatic bit m_enable();
    return (m_mode == M_RUN) || (m_mode == M_STEP && step);
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      m_mode = M_IDLE; m_pc = 32'h0; m_cnt = 32'h0; m_cnt4 = 0; m_err = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      logic [31:0] npc;
      logic        nerr;
      npc = m_pc;
      nerr = 1'b0;
      if (m_enable()) begin
        if (exc) npc = 32'h80;
        else if (branch) begin
          if (bt % 4 != 0) begin npc = 32'h80; nerr = 1'b1; end
          else npc = bt;
        end
        else if (stall) npc = m_pc;
        else if (jump) begin
          if (jt % 4 != 0) begin npc = 32'h80; nerr = 1'b1; end
          else npc = jt;
        end
        else npc = m_pc + 32'd4;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        if (m_cnt4 < 15) m_cnt4 = m_cnt4 + 1;
        if (halt && !exc && !branch) m_mode = M_HALT;
      end
      if (m_mode == M_IDLE && start) m_mode = step_mode ? M_STEP : M_RUN;
      m_pc = npc;
      m_err = nerr;
    end
  end

  // Per-cycle comparison, mid-cycle away from the falling update edge.
  always @(posedge clk) begin
    if (m_valid) begin
      chk("pc", pc, m_pc);
      chk("pc_plus", pc_plus, m_pc + 32'd4);
      chk("enable", {31'b0, en}, {31'b0, m_enable()});
      chk("halted", {31'b0, halted}, {31'b0, m_mode == M_HALT});
      chk("addr_err", {31'b0, aerr}, {31'b0, m_err});
      chk("count", cnt, m_cnt);
      chk("count4", {28'b0, cnt4}, m_cnt4);
    end
  end

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] r;
    // Reset and free run
    nxt(); nxt();
    chk("rst_pc", pc, 32'h0);
    chk("rst_cnt", cnt, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    chk("rst_enable", {31'b0, en}, 32'h0);
    rst = 1'b1; start = 1'b1; step_mode = 1'b0;
    nxt();
    start = 1'b0;
    chk("run_pc0", pc, 32'h0);
    repeat (4) nxt();
    chk("run_pc16", pc, 32'h10);
    chk("run_cnt4", cnt, 32'd4);
    chk("run_plus", pc_plus, 32'h14);
    // Stall blocks jump, branch flushes through stall
    stall = 1'b1; jump = 1'b1; jt = 32'h40;
    nxt();
    chk("stall_jump", pc, 32'h10);
    jump = 1'b0; branch = 1'b1; bt = 32'h100;
    nxt();
    chk("stall_branch", pc, 32'h100);
    stall = 1'b0;
    // Exception beats branch; misaligned jump
    exc = 1'b1; bt = 32'h200;
    nxt();
    chk("exc_pc", pc, 32'h80);
    exc = 1'b0; branch = 1'b0; jump = 1'b1; jt = 32'h42;
    nxt();
    chk("misalign_pc", pc, 32'h80);
    chk("misalign_err", {31'b0, aerr}, 32'h1);
    jump = 1'b0;
    nxt();
    chk("err_pulse_end", {31'b0, aerr}, 32'h0);
    chk("after_err_pc", pc, 32'h84);
    // Wrap-around
    branch = 1'b1; bt = 32'hFFFF_FFFC;
    nxt();
    chk("wrap_plus", pc_plus, 32'h0);
    branch = 1'b0;
    nxt();
    chk("wrap_pc", pc, 32'h0);
    // Halt flushed by branch
    halt = 1'b1; branch = 1'b1; bt = 32'h10;
    nxt();
    chk("halt_flushed", {31'b0, halted}, 32'h0);
    chk("halt_flushed_pc", pc, 32'h10);
    halt = 1'b0; branch = 1'b0;
    repeat (5) nxt();
    chk("cnt17", cnt, 32'd17);
    chk("cnt4_sat", {28'b0, cnt4}, 32'd15);
    // Reset mid-run
    rst = 1'b0;
    nxt();
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_cnt", cnt, 32'h0);
    chk("midrst_en", {31'b0, en}, 32'h0);
    rst = 1'b1;
    // Single-step
    step_mode = 1'b1; start = 1'b1;
    nxt();
    start = 1'b0;
    repeat (5) nxt();
    chk("step_idle_pc", pc, 32'h0);
    chk("step_idle_cnt", cnt, 32'h0);
    step = 1'b1; nxt(); step = 1'b0; nxt(); step = 1'b1; nxt(); step = 1'b0;
    chk("step_pc", pc, 32'h8);
    chk("step_cnt", cnt, 32'd2);
    halt = 1'b1; step = 1'b1;
    nxt();
    halt = 1'b0; step = 1'b0;
    chk("step_halt_pc", pc, 32'hC);
    chk("step_halted", {31'b0, halted}, 32'h1);
    // Halt in run mode
    rst = 1'b0; nxt(); rst = 1'b1; step_mode = 1'b0; start = 1'b1;
    nxt();
    start = 1'b0; branch = 1'b1; bt = 32'h20;
    nxt();
    branch = 1'b0; halt = 1'b1;
    nxt();
    halt = 1'b0;
    repeat (10) nxt();
    chk("halt_pc", pc, 32'h24);
    chk("halt_flag", {31'b0, halted}, 32'h1);
    chk("halt_cnt", cnt, 32'd2);
    // Randomized traffic
    for (int ep = 0; ep < 6; ep++) begin
      rst = 1'b0; nxt(); rst = 1'b1;
      step_mode = 1'($urandom % 2); start = 1'b1;
      nxt();
      for (int c = 0; c < 300; c++) begin
        start  = ($urandom % 50 == 0);
        stall  = ($urandom % 4 == 0);
        exc    = ($urandom % 16 == 0);
        branch = ($urandom % 6 == 0);
        jump   = ($urandom % 6 == 0);
        halt   = ($urandom % 64 == 0);
        step   = 1'($urandom % 2);
        rst    = ($urandom % 200 != 0);
        r = $urandom;
        bt = (r & 32'hFFFF_FFFC) | (($urandom % 5 == 0) ? 32'($urandom % 4) : 32'h0);
        r = $urandom;
        jt = (r & 32'hFFFF_FFFC) | (($urandom % 5 == 0) ? 32'($urandom % 4) : 32'h0);
        nxt();
      end
    end
    rst = 1'b1; start = 1'b0; exc = 1'b0; branch = 1'b0; jump = 1'b0; halt = 1'b0;
    nxt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
